// File: rtl/pc_reg_stack.sv
// pc_reg_stack: program-counter register with increment, absolute load, relative
// branch and a CALL/RET return-address stack. One op per enabled clock.
// All outputs come from registers.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         op enable; 0 holds pc, sp, stack and err (clr_err_i still acts)
//   op_i         operation code (HOLD, INC, LOAD, BRANCH, CALL, RET, 2 illegal)
//   l_value_i    absolute target for LOAD and CALL
//   offset_i     two's-complement displacement for BRANCH
//   clr_err_i    synchronous clear of the sticky error flag
//   pc_o         current program counter (instruction-fetch address)
//   sp_o         number of occupied return-stack entries
//   stk_full_o   sp_o == Depth
//   stk_empty_o  sp_o == 0
//   err_o        sticky overflow / underflow / illegal-op flag
module pc_reg_stack #(
   parameter int unsigned Width   = 6,
   parameter int unsigned Step    = 1,
   parameter int unsigned ResetPc = 0,
   parameter int unsigned Depth   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [2:0]                 op_i,
   input  logic [Width-1:0]           l_value_i,
   input  logic [Width-1:0]           offset_i,
   input  logic                       clr_err_i,
   output logic [Width-1:0]           pc_o,
   output logic [$clog2(Depth+1)-1:0] sp_o,
   output logic                       stk_full_o,
   output logic                       stk_empty_o,
   output logic                       err_o
);

   localparam int unsigned SpW   = $clog2(Depth + 1);
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef enum logic [2:0] {
      OpHold   = 3'b000,
      OpInc    = 3'b001,
      OpLoad   = 3'b010,
      OpBranch = 3'b011,
      OpCall   = 3'b100,
      OpRet    = 3'b101
   } op_e;

   logic [Width-1:0] pc_q, pc_d;
   logic [SpW-1:0]   sp_q, sp_d;
   logic             err_q, err_d;
   logic             full, empty;
   logic             push, set_err;
   logic [Width-1:0] pc_next_seq;
   logic [AddrW-1:0] wr_idx, rd_idx;

   // Return-address storage; contents are don't-care after reset, so no reset.
   logic [Width-1:0] stack_q [2**AddrW];

   assign full        = (sp_q == SpW'(Depth));
   assign empty       = (sp_q == '0);
   assign pc_next_seq = pc_q + Width'(Step);
   assign wr_idx      = AddrW'(sp_q);
   assign rd_idx      = AddrW'(sp_q - SpW'(1));

   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      push    = 1'b0;
      set_err = 1'b0;
      if (en_i) begin
         case (op_i)
            OpHold:   ;
            OpInc:    pc_d = pc_next_seq;
            OpLoad:   pc_d = l_value_i;
            OpBranch: pc_d = pc_q + offset_i;
            OpCall: begin
               if (full) begin
                  set_err = 1'b1;
               end else begin
                  push = 1'b1;
                  sp_d = sp_q + SpW'(1);
                  pc_d = l_value_i;
               end
            end
            OpRet: begin
               if (empty) begin
                  set_err = 1'b1;
               end else begin
                  sp_d = sp_q - SpW'(1);
                  pc_d = stack_q[rd_idx];
               end
            end
            default:  set_err = 1'b1;
         endcase
      end
      // A new error beats a clear in the same cycle.
      if (set_err) begin
         err_d = 1'b1;
      end else if (clr_err_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q  <= Width'(ResetPc);
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         stack_q[wr_idx] <= pc_next_seq;
      end
   end

   assign pc_o        = pc_q;
   assign sp_o        = sp_q;
   assign stk_full_o  = full;
   assign stk_empty_o = empty;
   assign err_o       = err_q;

endmodule

// File: tb/tb_pc_reg_stack.sv
// Testbench for pc_reg_stack (default parameters: Width 6, Step 1, ResetPc 0, Depth 4).
// Directed vector table, an asynchronous reset check, then random ops against a
// queue-based reference model.
module tb_pc_reg_stack;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       en_i;
   logic [2:0] op_i;
   logic [5:0] l_value_i;
   logic [5:0] offset_i;
   logic       clr_err_i;
   logic [5:0] pc_o;
   logic [2:0] sp_o;
   logic       stk_full_o;
   logic       stk_empty_o;
   logic       err_o;

   int n_cmp  = 0;
   int n_fail = 0;

   pc_reg_stack dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .op_i        (op_i),
      .l_value_i   (l_value_i),
      .offset_i    (offset_i),
      .clr_err_i   (clr_err_i),
      .pc_o        (pc_o),
      .sp_o        (sp_o),
      .stk_full_o  (stk_full_o),
      .stk_empty_o (stk_empty_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       en;
      logic [2:0] op;
      logic [5:0] lval;
      logic [5:0] off;
      logic       clr;
      logic [5:0] pc;
      logic [2:0] sp;
      logic       err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int pc, input int sp, input bit err);
      chk({tag, " pc"}, 32'(pc_o), 32'(pc));
      chk({tag, " sp"}, 32'(sp_o), 32'(sp));
      chk({tag, " err"}, 32'(err_o), 32'(err));
      chk({tag, " full"}, 32'(stk_full_o), 32'(sp == 4));
      chk({tag, " empty"}, 32'(stk_empty_o), 32'(sp == 0));
   endtask

   task automatic drive(input logic en, input logic [2:0] op, input logic [5:0] lv,
                        input logic [5:0] off, input logic clr);
      en_i = en; op_i = op; l_value_i = lv; offset_i = off; clr_err_i = clr;
      @(posedge clk_i);
      #1;
   endtask

   vec_t vecs[$];

   function automatic vec_t v(logic en, logic [2:0] op, logic [5:0] lv, logic [5:0] off,
                              logic clr, logic [5:0] pc, logic [2:0] sp, logic err);
      vec_t r;
      r.en = en; r.op = op; r.lval = lv; r.off = off; r.clr = clr;
      r.pc = pc; r.sp = sp; r.err = err;
      return r;
   endfunction

   // Reference model state
   int         m_pc;
   logic [5:0] m_stk[$];
   bit         m_err;

   task automatic model_step(input bit en, input int op, input int lv, input int off,
                             input bit clr);
      bit e;
      e = 0;
      if (en) begin
         case (op)
            1: m_pc = (m_pc + 1) % 64;
            2: m_pc = lv;
            3: m_pc = (m_pc + off) % 64;
            4: if (m_stk.size() == 4) e = 1;
               else begin m_stk.push_back(6'((m_pc + 1) % 64)); m_pc = lv; end
            5: if (m_stk.size() == 0) e = 1;
               else m_pc = int'(m_stk.pop_back());
            6, 7: e = 1;
            default: ;
         endcase
      end
      if (e) m_err = 1;
      else if (clr) m_err = 0;
   endtask

   initial begin
      rst_ni = 1'b0; en_i = 0; op_i = 0; l_value_i = 0; offset_i = 0; clr_err_i = 0;
      #12;
      chk_all("reset", 0, 0, 0);
      rst_ni = 1'b1;
      #2;

      // INC x3, wrap, branch -1
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 6'd1, 0, 0));
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 6'd2, 0, 0));
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 6'd3, 0, 0));
      vecs.push_back(v(1, 3'd2, 6'h3E, 0, 0, 6'h3E, 0, 0));
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 6'h3F, 0, 0));
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 6'h00, 0, 0));
      vecs.push_back(v(1, 3'd3, 0, 6'h3F, 0, 6'h3F, 0, 0));
      // Nested call / return
      vecs.push_back(v(1, 3'd2, 6'd5, 0, 0, 6'd5, 0, 0));
      vecs.push_back(v(1, 3'd4, 6'd20, 0, 0, 6'd20, 1, 0));
      vecs.push_back(v(1, 3'd4, 6'd40, 0, 0, 6'd40, 2, 0));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd21, 1, 0));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd6, 0, 0));
      // Fill to Depth, overflow, LIFO unwind, underflow
      vecs.push_back(v(1, 3'd4, 6'd10, 0, 0, 6'd10, 1, 0));
      vecs.push_back(v(1, 3'd4, 6'd20, 0, 0, 6'd20, 2, 0));
      vecs.push_back(v(1, 3'd4, 6'd30, 0, 0, 6'd30, 3, 0));
      vecs.push_back(v(1, 3'd4, 6'd40, 0, 0, 6'd40, 4, 0));
      vecs.push_back(v(1, 3'd4, 6'd50, 0, 0, 6'd40, 4, 1));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd31, 3, 1));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd21, 2, 1));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd11, 1, 1));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd7, 0, 1));
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 6'd7, 0, 1));
      // Error clear / set priority / enable gating
      vecs.push_back(v(1, 3'd0, 0, 0, 1, 6'd7, 0, 0));
      vecs.push_back(v(1, 3'd6, 6'd33, 0, 1, 6'd7, 0, 1));
      vecs.push_back(v(0, 3'd1, 0, 0, 0, 6'd7, 0, 1));
      vecs.push_back(v(0, 3'd0, 0, 0, 1, 6'd7, 0, 0));
      vecs.push_back(v(1, 3'd7, 6'd12, 6'd3, 0, 6'd7, 0, 1));
      vecs.push_back(v(0, 3'd4, 6'd12, 0, 0, 6'd7, 0, 1));
      vecs.push_back(v(1, 3'd2, 6'd0, 0, 1, 6'd0, 0, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].op, vecs[i].lval, vecs[i].off, vecs[i].clr);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].pc), int'(vecs[i].sp), vecs[i].err);
      end

      // Asynchronous reset between edges with live state
      drive(1, 3'd4, 6'd9, 0, 0);
      drive(1, 3'd6, 0, 0, 0);
      en_i = 0;
      #3;
      rst_ni = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Random ops against the reference model
      m_pc = 0; m_err = 0; m_stk.delete();
      for (int i = 0; i < 500; i++) begin
         logic en, clr;
         logic [2:0] op;
         logic [5:0] lv, off;
         en  = ($urandom_range(0, 9) != 0);
         op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                            : 3'($urandom_range(0, 5));
         lv  = 6'($urandom);
         off = 6'($urandom);
         clr = ($urandom_range(0, 7) == 0);
         drive(en, op, lv, off, clr);
         model_step(en, int'(op), int'(lv), int'(off), clr);
         chk_all($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
